// File: rtl/jtag_load_sequencer.sv
// jtag_load_sequencer
// TCK-domain controller that sits behind the TAP state machine. It holds the
// instruction register, decodes it into one of three data chains, muxes TDO,
// and turns each completed LOAD_PROGRAM DR scan into one instruction-memory
// write at an auto-incrementing word address. The core is held in reset for
// the whole load session.
//
// Ports:
//   tck_i, rst_i           clock and synchronous active-high reset
//   tdi_i, tdo_o           serial data in / registered serial data out
//   captureIR_i .. updateDR_i  one-hot TAP state strobes
//   mem_wvalid_o/wready_i  valid/ready write handshake to instruction memory
//   mem_waddr_o/wdata_o    word address and data of the pending write
//   cpu_rst_o              core reset, high while a load session is open
//   load_done_o            one-cycle pulse when a session closes
module jtag_load_sequencer #(
    parameter int unsigned             IR_WIDTH        = 4,
    parameter int unsigned             DATA_WIDTH      = 32,
    parameter int unsigned             ADDR_WIDTH      = 10,
    parameter logic [IR_WIDTH-1:0]     OP_LOAD_PROGRAM = 4'b0001,
    parameter logic [IR_WIDTH-1:0]     OP_SCAN_TEST    = 4'b0010,
    parameter logic [IR_WIDTH-1:0]     OP_BYPASS       = 4'b0011
) (
    input  logic                  tck_i,
    input  logic                  rst_i,
    input  logic                  tdi_i,
    input  logic                  captureIR_i,
    input  logic                  shiftIR_i,
    input  logic                  updateIR_i,
    input  logic                  captureDR_i,
    input  logic                  shiftDR_i,
    input  logic                  updateDR_i,
    output logic                  tdo_o,
    output logic                  mem_wvalid_o,
    input  logic                  mem_wready_i,
    output logic [ADDR_WIDTH-1:0] mem_waddr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic                  cpu_rst_o,
    output logic                  load_done_o
);

    localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {StIdle, StArmed, StWrite, StFinish} state_e;

    state_e                state_q, state_d;
    logic [IR_WIDTH-1:0]   ir_q;
    logic [IR_WIDTH-1:0]   ir_shift_q;
    logic                  bypass_q;
    logic [DATA_WIDTH-1:0] load_dr_q;
    logic [DATA_WIDTH-1:0] scan_dr_q;
    logic                  tdo_q;
    logic [CNT_WIDTH-1:0]  word_cnt_q, word_cnt_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  full_q, full_d;
    logic                  overrun_q, overrun_d;
    logic                  fin_pend_q, fin_pend_d;

    logic                  sel_load, sel_scan;
    logic                  upd_ir, upd_dr_load;
    logic                  ir_new_load, ir_new_other;
    logic                  finish_req;
    logic                  dr_bit0;
    logic [15:0]           cnt16;
    logic [DATA_WIDTH-1:0] status;

    // Anything that is neither LOAD_PROGRAM nor SCAN_TEST selects BYPASS.
    assign sel_load = (ir_q == OP_LOAD_PROGRAM);
    assign sel_scan = (ir_q == OP_SCAN_TEST);

    // Strobe priority within a path is capture > shift > update.
    assign upd_ir       = updateIR_i && !captureIR_i && !shiftIR_i;
    assign upd_dr_load  = updateDR_i && !captureDR_i && !shiftDR_i && sel_load;
    // The opcode being committed is the one still sitting in the IR shifter.
    assign ir_new_load  = upd_ir && (ir_shift_q == OP_LOAD_PROGRAM);
    assign ir_new_other = upd_ir && (ir_shift_q != OP_LOAD_PROGRAM);
    assign finish_req   = fin_pend_q || ir_new_other;

    assign cnt16 = 16'(word_cnt_q);

    always_comb begin
        status                 = '0;
        status[DATA_WIDTH-1]   = full_q;
        status[DATA_WIDTH-2]   = overrun_q;
        status[15:0]           = cnt16;
    end

    always_comb begin
        dr_bit0 = bypass_q;
        if (sel_load) begin
            dr_bit0 = load_dr_q[0];
        end else if (sel_scan) begin
            dr_bit0 = scan_dr_q[0];
        end
    end

    // IR/DR chains and TDO. TDO registers the pre-shift LSB, so each shift
    // edge presents the bit that the chain is shifting out.
    always_ff @(posedge tck_i) begin
        if (rst_i) begin
            ir_q       <= OP_BYPASS;
            ir_shift_q <= '0;
            bypass_q   <= 1'b0;
            load_dr_q  <= '0;
            scan_dr_q  <= '0;
            tdo_q      <= 1'b0;
        end else begin
            if (captureIR_i) begin
                ir_shift_q <= IR_WIDTH'(2'b01);
            end else if (shiftIR_i) begin
                ir_shift_q <= {tdi_i, ir_shift_q[IR_WIDTH-1:1]};
            end else if (updateIR_i) begin
                ir_q <= ir_shift_q;
            end

            if (captureDR_i) begin
                if (sel_load) begin
                    load_dr_q <= DATA_WIDTH'(word_cnt_q);
                end else if (sel_scan) begin
                    scan_dr_q <= status;
                end else begin
                    bypass_q <= 1'b0;
                end
            end else if (shiftDR_i) begin
                if (sel_load) begin
                    load_dr_q <= {tdi_i, load_dr_q[DATA_WIDTH-1:1]};
                end else if (sel_scan) begin
                    scan_dr_q <= {tdi_i, scan_dr_q[DATA_WIDTH-1:1]};
                end else begin
                    bypass_q <= tdi_i;
                end
            end

            tdo_q <= shiftIR_i ? ir_shift_q[0] : dr_bit0;
        end
    end

    // FSM state register plus the session datapath it owns.
    always_ff @(posedge tck_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            word_cnt_q <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            full_q     <= 1'b0;
            overrun_q  <= 1'b0;
            fin_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            full_q     <= full_d;
            overrun_q  <= overrun_d;
            fin_pend_q <= fin_pend_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        full_d     = full_q;
        overrun_d  = overrun_q;
        fin_pend_d = fin_pend_q;

        case (state_q)
            StIdle, StArmed: begin
                if (ir_new_load) begin
                    // Arm, or restart an open session from scratch.
                    state_d    = StArmed;
                    word_cnt_d = '0;
                    waddr_d    = '0;
                    full_d     = 1'b0;
                    overrun_d  = 1'b0;
                    fin_pend_d = 1'b0;
                end else if (state_q == StArmed) begin
                    if (ir_new_other) begin
                        state_d = StFinish;
                    end else if (upd_dr_load && !full_q) begin
                        wdata_d = load_dr_q;
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                if (ir_new_other) begin
                    fin_pend_d = 1'b1;
                end
                // A word arriving while one is still pending is dropped.
                if (upd_dr_load) begin
                    overrun_d = 1'b1;
                end
                if (mem_wready_i) begin
                    word_cnt_d = word_cnt_q + CNT_WIDTH'(1);
                    // Saturate at the top word instead of wrapping.
                    if (waddr_q == {ADDR_WIDTH{1'b1}}) begin
                        full_d = 1'b1;
                    end else begin
                        waddr_d = waddr_q + ADDR_WIDTH'(1);
                    end
                    fin_pend_d = 1'b0;
                    state_d    = finish_req ? StFinish : StArmed;
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs.
    always_comb begin
        mem_wvalid_o = (state_q == StWrite);
        cpu_rst_o    = (state_q == StArmed) || (state_q == StWrite);
        load_done_o  = (state_q == StFinish);
        mem_waddr_o  = waddr_q;
        mem_wdata_o  = wdata_q;
        tdo_o        = tdo_q;
    end

endmodule

// File: tb/tb_jtag_load_sequencer.sv
module tb_jtag_load_sequencer;

    localparam int AW = 2;
    localparam int DW = 32;

    logic          tck_i = 1'b0;
    logic          rst_i;
    logic          tdi_i;
    logic          captureIR_i, shiftIR_i, updateIR_i;
    logic          captureDR_i, shiftDR_i, updateDR_i;
    logic          tdo_o;
    logic          mem_wvalid_o;
    logic          mem_wready_i;
    logic [AW-1:0] mem_waddr_o;
    logic [DW-1:0] mem_wdata_o;
    logic          cpu_rst_o;
    logic          load_done_o;

    jtag_load_sequencer #(.ADDR_WIDTH(AW)) dut (
        .tck_i        (tck_i),
        .rst_i        (rst_i),
        .tdi_i        (tdi_i),
        .captureIR_i  (captureIR_i),
        .shiftIR_i    (shiftIR_i),
        .updateIR_i   (updateIR_i),
        .captureDR_i  (captureDR_i),
        .shiftDR_i    (shiftDR_i),
        .updateDR_i   (updateDR_i),
        .tdo_o        (tdo_o),
        .mem_wvalid_o (mem_wvalid_o),
        .mem_wready_i (mem_wready_i),
        .mem_waddr_o  (mem_waddr_o),
        .mem_wdata_o  (mem_wdata_o),
        .cpu_rst_o    (cpu_rst_o),
        .load_done_o  (load_done_o)
    );

    always #5 tck_i = ~tck_i;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cycles;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  checks = 0;
    int  errors = 0;
    int  hi_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge tck_i);
        #1;
    endtask

    task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input int cyc);
        wr_t e;
        e.addr = a;
        e.data = d;
        e.cycles = cyc;
        exp_q.push_back(e);
    endtask

    // Returns the bits seen on tdo_o after each shift edge.
    task automatic ir_scan(input logic [3:0] op, output logic [3:0] outb);
        outb = '0;
        captureIR_i = 1'b1;
        tick();
        captureIR_i = 1'b0;
        shiftIR_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tdi_i = op[i];
            tick();
            outb[i] = tdo_o;
        end
        shiftIR_i = 1'b0;
        tdi_i = 1'b0;
        updateIR_i = 1'b1;
        tick();
        updateIR_i = 1'b0;
    endtask

    task automatic dr_scan(input logic [31:0] d, input int n, output logic [31:0] outb);
        outb = '0;
        captureDR_i = 1'b1;
        tick();
        captureDR_i = 1'b0;
        shiftDR_i = 1'b1;
        for (int i = 0; i < n; i++) begin
            tdi_i = d[i];
            tick();
            outb[i] = tdo_o;
        end
        shiftDR_i = 1'b0;
        tdi_i = 1'b0;
        updateDR_i = 1'b1;
        tick();
        updateDR_i = 1'b0;
    endtask

    // Scoreboard monitor: compares every accepted write against the queue,
    // including how many cycles valid was held before acceptance.
    always @(negedge tck_i) begin
        if (!rst_i && mem_wvalid_o) begin
            hi_cnt++;
            if (mem_wready_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %h data %h expected none",
                             mem_waddr_o, mem_wdata_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wr_addr", 32'(mem_waddr_o), 32'(mon_e.addr));
                    chk("wr_data", mem_wdata_o, mon_e.data);
                    chk("wr_valid_cycles", hi_cnt, mon_e.cycles);
                end
                hi_cnt = 0;
            end
        end else begin
            hi_cnt = 0;
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: got running expected finished");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

    logic [3:0]  irb;
    logic [31:0] drb;
    logic [31:0] prog [4];

    initial begin
        prog[0] = 32'h0000_0093;
        prog[1] = 32'h0010_0113;
        prog[2] = 32'hFFF0_0193;
        prog[3] = 32'h8000_0237;

        rst_i = 1'b1;
        tdi_i = 1'b0;
        captureIR_i = 1'b0; shiftIR_i = 1'b0; updateIR_i = 1'b0;
        captureDR_i = 1'b0; shiftDR_i = 1'b0; updateDR_i = 1'b0;
        mem_wready_i = 1'b1;
        tick();
        tick();
        chk("rst_tdo", 32'(tdo_o), 0);
        chk("rst_wvalid", 32'(mem_wvalid_o), 0);
        chk("rst_waddr", 32'(mem_waddr_o), 0);
        chk("rst_wdata", mem_wdata_o, 0);
        chk("rst_cpu_rst", 32'(cpu_rst_o), 0);
        chk("rst_load_done", 32'(load_done_o), 0);
        rst_i = 1'b0;
        tick();

        // Arm a load session.
        ir_scan(4'b0001, irb);
        chk("ir_capture_out", 32'(irb), 32'h1);
        chk("armed_cpu_rst", 32'(cpu_rst_o), 1);

        // Two back-to-back words with ready high.
        push_wr(2'd0, 32'hDEAD_BEEF, 1);
        dr_scan(32'hDEAD_BEEF, 32, drb);
        chk("load_capture_cnt0", drb, 0);
        chk("latency_wvalid", 32'(mem_wvalid_o), 1);
        tick();
        chk("wvalid_one_cycle", 32'(mem_wvalid_o), 0);
        push_wr(2'd1, 32'h0000_0013, 1);
        dr_scan(32'h0000_0013, 32, drb);
        chk("load_capture_cnt1", drb, 1);
        chk("latency_wvalid2", 32'(mem_wvalid_o), 1);
        tick();

        // Stall: ready low for five edges, an extra word arrives mid-stall.
        mem_wready_i = 1'b0;
        push_wr(2'd2, 32'hCAFE_F00D, 6);
        dr_scan(32'hCAFE_F00D, 32, drb);
        chk("load_capture_cnt2", drb, 2);
        chk("stall_wvalid", 32'(mem_wvalid_o), 1);
        tick();
        tick();
        updateDR_i = 1'b1;
        tick();
        updateDR_i = 1'b0;
        tick();
        tick();
        chk("stall_addr_hold", 32'(mem_waddr_o), 2);
        chk("stall_data_hold", mem_wdata_o, 32'hCAFE_F00D);
        chk("stall_wvalid_hold", 32'(mem_wvalid_o), 1);
        mem_wready_i = 1'b1;
        tick();
        chk("stall_release", 32'(mem_wvalid_o), 0);

        // Leaving via SCAN_TEST closes the session; status keeps its values.
        ir_scan(4'b0010, irb);
        chk("ir_capture_out2", 32'(irb), 32'h1);
        chk("finish_load_done", 32'(load_done_o), 1);
        chk("finish_cpu_rst", 32'(cpu_rst_o), 0);
        tick();
        chk("load_done_pulse", 32'(load_done_o), 0);
        dr_scan(32'h0, 32, drb);
        chk("status_overrun", drb, 32'h4000_0003);

        // Fill the 4-word memory, then one more word that must be ignored.
        ir_scan(4'b0001, irb);
        chk("rearm_cpu_rst", 32'(cpu_rst_o), 1);
        for (int i = 0; i < 4; i++) begin
            push_wr(AW'(i), prog[i], 1);
            dr_scan(prog[i], 32, drb);
            chk("fill_capture_cnt", drb, 32'(i));
            tick();
        end
        dr_scan(32'hBAD0_BAD0, 32, drb);
        chk("full_capture_cnt", drb, 4);
        chk("full_no_wvalid", 32'(mem_wvalid_o), 0);
        tick();
        chk("full_no_wvalid2", 32'(mem_wvalid_o), 0);
        chk("full_addr_no_wrap", 32'(mem_waddr_o), 3);

        // BYPASS closes the session and gives a one-shift delay chain.
        ir_scan(4'b0011, irb);
        chk("bypass_load_done", 32'(load_done_o), 1);
        chk("bypass_cpu_rst", 32'(cpu_rst_o), 0);
        tick();
        dr_scan(32'hD, 4, drb);
        chk("bypass_delay", drb, 32'hA);

        ir_scan(4'b0010, irb);
        dr_scan(32'h0, 32, drb);
        chk("status_full", drb, 32'h8000_0004);

        // Reset in the middle of a write discards it.
        ir_scan(4'b0001, irb);
        mem_wready_i = 1'b0;
        dr_scan(32'h0000_0055, 32, drb);
        chk("pre_rst_wvalid", 32'(mem_wvalid_o), 1);
        chk("pre_rst_tdo", 32'(tdo_o), 1);
        rst_i = 1'b1;
        tick();
        chk("midrst_wvalid", 32'(mem_wvalid_o), 0);
        chk("midrst_waddr", 32'(mem_waddr_o), 0);
        chk("midrst_wdata", mem_wdata_o, 0);
        chk("midrst_cpu_rst", 32'(cpu_rst_o), 0);
        chk("midrst_tdo", 32'(tdo_o), 0);
        chk("midrst_load_done", 32'(load_done_o), 0);
        rst_i = 1'b0;
        tick();
        // With the IR back at BYPASS the DR path is the 1-bit delay again.
        dr_scan(32'hD, 4, drb);
        chk("midrst_ir_bypass", drb, 32'hA);
        tick();
        chk("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
